// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time RV32I load/store initiator for a word-only
// data memory. Sub-word loads are lane-selected and extended. Sub-word stores
// are done as a read-modify-write. Misaligned or illegal requests complete
// with resp_err and never reach memory.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  // DONE is folded into the completing edge, so it never appears here.
  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR} state_t;

  // Only what is needed after accept: op kind, lane bits, and the low half
  // of the store data (SW forwards its full word at accept).
  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic [15:0] wdata;
  } op_t;

  state_t state;
  op_t    op;

  // Misaligned halves/words and funct3 codes outside the RV32I load/store set.
  function automatic logic acc_err(input logic st, input logic [2:0] f3,
                                   input logic [1:0] lo);
    logic e;
    e = 1'b0;
    case (f3)
      3'b000:          e = 1'b0;
      3'b001:          e = lo[0];
      3'b010:          e = (lo != 2'b00);
      3'b100:          e = st;
      3'b101:          e = st | lo[0];
      default:         e = 1'b1;
    endcase
    return e;
  endfunction

  // Pick the addressed byte/half and sign- or zero-extend it.
  function automatic logic [31:0] load_ext(input logic [2:0] f3,
                                           input logic [1:0] lane,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'b0, b};
      3'b101:  r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overlay the store byte/half onto the word just read; other lanes keep
  // their read value.
  function automatic logic [31:0] store_merge(input logic [2:0] f3,
                                              input logic [1:0] lane,
                                              input logic [31:0] word,
                                              input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    if (f3 == 3'b000) begin
      for (int i = 0; i < 4; i++)
        if (i == int'(lane)) r[8*i +: 8] = wd[7:0];
    end else if (lane[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    return r;
  endfunction

  assign req_ready = (state == IDLE);

  // Request FSM with registered memory strobes and response pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op         <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op <= '{store: req_store, funct3: req_funct3,
                    lane: req_addr[1:0], wdata: req_wdata[15:0]};
            if (acc_err(req_store, req_funct3, req_addr[1:0])) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              mem_addr <= {req_addr[31:2], 2'b00};
              if (req_store && req_funct3 == 3'b010) begin
                mem_write <= 1'b1;
                mem_wdata <= req_wdata;
                state     <= WR;
              end else begin
                // Loads and sub-word stores both start with a read.
                mem_read <= 1'b1;
                state    <= RD_REQ;
              end
            end
          end
        end
        RD_REQ: begin
          if (mem_ready) begin
            mem_read <= 1'b0;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_ready) begin
            if (op.store) begin
              mem_wdata <= store_merge(op.funct3, op.lane, mem_rdata, op.wdata);
              mem_write <= 1'b1;
              state     <= WR;
            end else begin
              resp_rdata <= load_ext(op.funct3, op.lane, mem_rdata);
              resp_valid <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        WR: begin
          if (mem_ready) begin
            mem_write  <= 1'b0;
            resp_valid <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit. The memory model samples a request on an edge
// with mem_ready=1 and, for a read, returns the word on the following edge;
// hold forces mem_ready low to model a busy memory (including the busy cycle
// after a read sample).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        hold = 1'b0;
  logic        mem_ready;

  assign mem_ready = ~hold;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Memory: contents owned by the stimulus block, activity logged here.
  logic [31:0] mem [64];
  int          nrd = 0, nwr = 0, rd_hi = 0;
  logic [31:0] last_ra = '0, last_wa = '0, last_wd = '0;
  logic        both_seen = 1'b0;

  // Memory model and activity monitor.
  always @(posedge clk) begin
    if (mem_read) rd_hi <= rd_hi + 1;
    if (mem_read && mem_write) both_seen <= 1'b1;
    if (mem_ready && mem_read) begin
      nrd       <= nrd + 1;
      last_ra   <= mem_addr;
      mem_rdata <= mem[mem_addr[7:2]];
    end else if (mem_ready && mem_write) begin
      nwr     <= nwr + 1;
      last_wa <= mem_addr;
      last_wd <= mem_wdata;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present a request in the current cycle and wait (bounded) for resp_valid.
  // lat = number of edges from the accept edge to the first edge that sees
  // resp_valid high.
  task automatic do_req(input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, output int lat);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  typedef struct {
    string       nm;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] word;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          nrd;
    int          nwr;
    logic [31:0] wd;
  } vec_t;

  vec_t vt [18];

  initial begin
    int lat, r0, w0, h0, seen;
    vt[0]  = '{"lw40",   1'b0, 3'b010, 32'h40, 32'h0,        32'h8765_4321, 3, 1'b0, 32'h8765_4321, 1, 0, 32'h0};
    vt[1]  = '{"lb43",   1'b0, 3'b000, 32'h43, 32'h0,        32'h80FF_7F01, 3, 1'b0, 32'hFFFF_FF80, 1, 0, 32'h0};
    vt[2]  = '{"lbu43",  1'b0, 3'b100, 32'h43, 32'h0,        32'h80FF_7F01, 3, 1'b0, 32'h0000_0080, 1, 0, 32'h0};
    vt[3]  = '{"lh42",   1'b0, 3'b001, 32'h42, 32'h0,        32'h80FF_7F01, 3, 1'b0, 32'hFFFF_80FF, 1, 0, 32'h0};
    vt[4]  = '{"lhu42",  1'b0, 3'b101, 32'h42, 32'h0,        32'h80FF_7F01, 3, 1'b0, 32'h0000_80FF, 1, 0, 32'h0};
    vt[5]  = '{"lb41",   1'b0, 3'b000, 32'h41, 32'h0,        32'h80FF_7F01, 3, 1'b0, 32'h0000_007F, 1, 0, 32'h0};
    vt[6]  = '{"lh40",   1'b0, 3'b001, 32'h40, 32'h0,        32'h80FF_7F01, 3, 1'b0, 32'h0000_7F01, 1, 0, 32'h0};
    vt[7]  = '{"sb41",   1'b1, 3'b000, 32'h41, 32'hFFFF_FFAB, 32'h1122_3344, 4, 1'b0, 32'h0, 1, 1, 32'h1122_AB44};
    vt[8]  = '{"sw44",   1'b1, 3'b010, 32'h44, 32'hDEAD_BEEF, 32'h0,         2, 1'b0, 32'h0, 0, 1, 32'hDEAD_BEEF};
    vt[9]  = '{"sh46",   1'b1, 3'b001, 32'h46, 32'h1234_CAFE, 32'h1122_3344, 4, 1'b0, 32'h0, 1, 1, 32'hCAFE_3344};
    vt[10] = '{"sh44",   1'b1, 3'b001, 32'h44, 32'h0000_BEEF, 32'h1122_3344, 4, 1'b0, 32'h0, 1, 1, 32'h1122_BEEF};
    vt[11] = '{"sb43",   1'b1, 3'b000, 32'h43, 32'h0000_005A, 32'h1122_3344, 4, 1'b0, 32'h0, 1, 1, 32'h5A22_3344};
    vt[12] = '{"lw42",   1'b0, 3'b010, 32'h42, 32'h0,        32'h0,         1, 1'b1, 32'h0, 0, 0, 32'h0};
    vt[13] = '{"sh41",   1'b1, 3'b001, 32'h41, 32'h0,        32'h0,         1, 1'b1, 32'h0, 0, 0, 32'h0};
    vt[14] = '{"ld011",  1'b0, 3'b011, 32'h40, 32'h0,        32'h0,         1, 1'b1, 32'h0, 0, 0, 32'h0};
    vt[15] = '{"st100",  1'b1, 3'b100, 32'h40, 32'h0,        32'h0,         1, 1'b1, 32'h0, 0, 0, 32'h0};
    vt[16] = '{"lhu43",  1'b0, 3'b101, 32'h43, 32'h0,        32'h0,         1, 1'b1, 32'h0, 0, 0, 32'h0};
    vt[17] = '{"lw41",   1'b0, 3'b010, 32'h41, 32'h0,        32'h0,         1, 1'b1, 32'h0, 0, 0, 32'h0};
    for (int i = 0; i < 64; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_req_ready",  32'(req_ready),  32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_err",   32'(resp_err),   32'h0);
    chk("rst_mem_read",   32'(mem_read),   32'h0);
    chk("rst_mem_write",  32'(mem_write),  32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_addr",   mem_addr,   32'h0);
    chk("rst_mem_wdata",  mem_wdata,  32'h0);

    // Table: each request issued in the previous response cycle (back-to-back).
    for (int i = 0; i < 18; i++) begin
      mem[vt[i].addr[7:2]] = vt[i].word;
      r0 = nrd; w0 = nwr; h0 = rd_hi;
      do_req(vt[i].st, vt[i].f3, vt[i].addr, vt[i].wdata, lat);
      chk({vt[i].nm, "_lat"},   32'(lat), 32'(vt[i].lat));
      chk({vt[i].nm, "_err"},   32'(resp_err), 32'(vt[i].err));
      chk({vt[i].nm, "_ready"}, 32'(req_ready), 32'h1);
      chk({vt[i].nm, "_nrd"},   32'(nrd - r0), 32'(vt[i].nrd));
      chk({vt[i].nm, "_nwr"},   32'(nwr - w0), 32'(vt[i].nwr));
      chk({vt[i].nm, "_rdhi"},  32'(rd_hi - h0), 32'(vt[i].nrd));
      if (!vt[i].st && !vt[i].err)
        chk({vt[i].nm, "_rdata"}, resp_rdata, vt[i].rdata);
      if (vt[i].nrd > 0)
        chk({vt[i].nm, "_raddr"}, last_ra, {vt[i].addr[31:2], 2'b00});
      if (vt[i].nwr > 0) begin
        chk({vt[i].nm, "_waddr"}, last_wa, {vt[i].addr[31:2], 2'b00});
        chk({vt[i].nm, "_wdata"}, last_wd, vt[i].wd);
      end
    end

    // Memory busy for 3 cycles while the read request is pending.
    mem[18] = 32'h0BAD_F00D;
    r0 = nrd; h0 = rd_hi;
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h48;
    @(posedge clk); #1;
    req_valid = 1'b0; hold = 1'b1;
    chk("stall_busy_ready", 32'(req_ready), 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    chk("stall_read_held", 32'(mem_read), 32'h1);
    chk("stall_addr",      mem_addr, 32'h48);
    hold = 1'b0;
    lat = 4;
    while (!resp_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    chk("stall_lat",   32'(lat), 32'd6);
    chk("stall_rdata", resp_rdata, 32'h0BAD_F00D);
    chk("stall_nrd",   32'(nrd - r0), 32'd1);
    chk("stall_rdhi",  32'(rd_hi - h0), 32'd4);

    // One busy cycle after the read sample: one extra cycle of latency.
    mem[19] = 32'hC001_D00D;
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4C;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    hold = 1'b1;
    chk("busy_read_cleared", 32'(mem_read), 32'h0);
    @(posedge clk); #1;
    hold = 1'b0;
    lat = 3;
    while (!resp_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    chk("busy_lat",   32'(lat), 32'd4);
    chk("busy_rdata", resp_rdata, 32'hC001_D00D);

    // Reset while an LH is waiting for its read data.
    mem[16] = 32'h80FF_7F01;
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b001; req_addr = 32'h42;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    hold = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    hold = 1'b0; rst = 1'b0;
    chk("abort_req_ready",  32'(req_ready),  32'h1);
    chk("abort_resp_valid", 32'(resp_valid), 32'h0);
    chk("abort_resp_err",   32'(resp_err),   32'h0);
    chk("abort_mem_read",   32'(mem_read),   32'h0);
    chk("abort_mem_write",  32'(mem_write),  32'h0);
    chk("abort_resp_rdata", resp_rdata, 32'h0);
    chk("abort_mem_addr",   mem_addr,   32'h0);
    chk("abort_mem_wdata",  mem_wdata,  32'h0);
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    chk("abort_no_resp", 32'(seen), 32'h0);
    mem[16] = 32'h8765_4321;
    do_req(1'b0, 3'b010, 32'h40, 32'h0, lat);
    chk("after_abort_lat",   32'(lat), 32'd3);
    chk("after_abort_err",   32'(resp_err), 32'h0);
    chk("after_abort_rdata", resp_rdata, 32'h8765_4321);

    chk("never_read_and_write", 32'(both_seen), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
